lap_recorder: RTL and testbench

- Writer side of the stopwatch lap memory: snapshots the running 4-digit BCD time into a circular store of DEPTH slots on a capture press.
- Replays stored laps on request, newest first, to the seg7/display path.
- Sits between the count block, which supplies the live digits, and the seg7 decoders.
- Button inputs are debounced levels from przycisk instances; this block does its own edge detection.

---
 rtl/lap_recorder_pkg.sv | 15 +
 rtl/lap_recorder_edge_rise.sv | 21 ++
 rtl/lap_recorder.sv | 147 ++++++++++++++
 tb/tb_lap_recorder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/lap_recorder_pkg.sv
// Shared stopwatch types and helpers for the lap memory.
package lap_recorder_pkg;

  localparam int BCD_W = 4;

  typedef enum logic {
    LIVE,
    RECALL
  } lap_state_e;

  function automatic logic bcd_ok(input logic [BCD_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/lap_recorder_edge_rise.sv
// Rising-edge detector for a debounced button level.
module edge_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  always_comb prev_d = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/lap_recorder.sv
// Lap memory for the stopwatch: captures BCD times into a circular store
// and replays them newest-first toward the seg7 path.
module lap_recorder
  import lap_recorder_pkg::*;
#(
  parameter int DEPTH  = 7,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BCD_W*DIGITS-1:0] time_in,
  input  logic                    capture,
  input  logic                    clear,
  input  logic                    recall,
  input  logic                    next,
  output logic [BCD_W*DIGITS-1:0] lap_out,
  output logic [2:0]              lap_idx,
  output logic [3:0]              lap_count,
  output logic                    full,
  output logic                    valid,
  output logic                    bad_bcd
);

  localparam int W     = BCD_W * DIGITS;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SUM_W = PTR_W + 1;
  localparam logic [3:0]       DEPTH_C  = 4'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic cap_edge, clr_edge, nxt_edge;

  edge_rise u_cap (.clk(clk), .rst_n(rst_n), .level(capture), .rise(cap_edge));
  edge_rise u_clr (.clk(clk), .rst_n(rst_n), .level(clear),   .rise(clr_edge));
  edge_rise u_nxt (.clk(clk), .rst_n(rst_n), .level(next),    .rise(nxt_edge));

  lap_state_e       state_d, state_q;
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_age_d, rd_age_q;
  logic [3:0]       count_d, count_q;
  logic             bad_d, bad_q;
  logic [W-1:0]     lap_out_d, lap_out_q;
  logic [2:0]       lap_idx_d, lap_idx_q;
  logic             valid_d, valid_q;
  logic             full_d, full_q;

  logic [W-1:0]     slot_q [DEPTH];
  logic             slot_we;
  logic             digits_ok;
  logic [SUM_W-1:0] rd_sum;
  logic [SUM_W-1:0] age_inc;
  logic [PTR_W-1:0] rd_idx;

  // Newest lap sits just behind wr_ptr; bias by DEPTH so the subtraction never underflows.
  always_comb begin
    rd_sum  = SUM_W'(wr_ptr_q) + SUM_W'(DEPTH - 1) - SUM_W'(rd_age_q);
    rd_idx  = (rd_sum >= SUM_W'(DEPTH)) ? PTR_W'(rd_sum - SUM_W'(DEPTH)) : PTR_W'(rd_sum);
    age_inc = SUM_W'(rd_age_q) + SUM_W'(1);
  end

  always_comb begin
    digits_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_ok(time_in[i*BCD_W +: BCD_W])) digits_ok = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_age_d = rd_age_q;
    count_d  = count_q;
    bad_d    = bad_q;
    slot_we  = 1'b0;

    if (clr_edge) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_age_d = '0;
      bad_d    = 1'b0;
    end else if (cap_edge) begin
      if (digits_ok) begin
        slot_we  = 1'b1;
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        count_d  = (count_q == DEPTH_C) ? count_q : count_q + 4'd1;
        rd_age_d = '0;
      end else begin
        bad_d = 1'b1;
      end
    end else if (nxt_edge && (state_q == RECALL) && (count_q != 4'd0)) begin
      rd_age_d = (age_inc == SUM_W'(count_q)) ? '0 : PTR_W'(age_inc);
    end

    case (state_q)
      LIVE: begin
        rd_age_d = '0;
        if (recall) state_d = RECALL;
      end
      RECALL: if (!recall) state_d = LIVE;
      default: state_d = LIVE;
    endcase

    // Display data trails the control outputs by one cycle.
    if (state_q == LIVE)          lap_out_d = time_in;
    else if (count_q == 4'd0)     lap_out_d = '0;
    else                          lap_out_d = slot_q[rd_idx];

    lap_idx_d = (state_d == RECALL) ? 3'(rd_age_d) : 3'd0;
    valid_d   = (state_d == RECALL) && (count_d != 4'd0);
    full_d    = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LIVE;
      wr_ptr_q  <= '0;
      rd_age_q  <= '0;
      count_q   <= '0;
      bad_q     <= 1'b0;
      lap_out_q <= '0;
      lap_idx_q <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_age_q  <= rd_age_d;
      count_q   <= count_d;
      bad_q     <= bad_d;
      lap_out_q <= lap_out_d;
      lap_idx_q <= lap_idx_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (slot_we) slot_q[wr_ptr_q] <= time_in;
  end

  assign lap_out   = lap_out_q;
  assign lap_idx   = lap_idx_q;
  assign lap_count = count_q;
  assign full      = full_q;
  assign valid     = valid_q;
  assign bad_bcd   = bad_q;

endmodule

// File: tb/tb_lap_recorder.sv
// Randomized and directed bench for lap_recorder against a queue-based lap model.
module tb_lap_recorder;

  localparam int DEPTH = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] time_in;
  logic        capture, clear, recall, next;
  logic [15:0] lap_out;
  logic [2:0]  lap_idx;
  logic [3:0]  lap_count;
  logic        full, valid, bad_bcd;

  int n_checks = 0;
  int n_errors = 0;

  lap_recorder #(.DEPTH(DEPTH), .DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .time_in(time_in), .capture(capture),
    .clear(clear), .recall(recall), .next(next), .lap_out(lap_out),
    .lap_idx(lap_idx), .lap_count(lap_count), .full(full), .valid(valid),
    .bad_bcd(bad_bcd)
  );

  always #5 clk = ~clk;

  // Reference model: laps held newest-first in a queue.
  logic [15:0] m_laps[$];
  bit          m_bad, m_recall_mode;
  int          m_age;
  bit          p_cap, p_clr, p_nxt;
  logic [15:0] e_out;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit all_bcd(input logic [15:0] t);
    for (int i = 0; i < 4; i++) if (((t >> (4*i)) & 16'hF) > 9) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    m_laps.delete();
    m_bad = 0; m_recall_mode = 0; m_age = 0;
    p_cap = 0; p_clr = 0; p_nxt = 0;
    e_out = '0;
  endtask

  task automatic check_outputs();
    chk("lap_out",   32'(lap_out),   32'(e_out));
    chk("lap_idx",   32'(lap_idx),   m_recall_mode ? 32'(m_age) : 32'd0);
    chk("lap_count", 32'(lap_count), 32'(m_laps.size()));
    chk("full",      32'(full),      32'(m_laps.size() == DEPTH));
    chk("valid",     32'(valid),     32'(m_recall_mode && m_laps.size() != 0));
    chk("bad_bcd",   32'(bad_bcd),   32'(m_bad));
  endtask

  // One clock: advance the model with the applied inputs, then compare.
  task automatic tick();
    bit ce, le, ne;
    logic [15:0] nout;
    ce = capture && !p_cap;
    le = clear && !p_clr;
    ne = next && !p_nxt;
    if (!m_recall_mode)          nout = time_in;
    else if (m_laps.size() == 0) nout = '0;
    else                         nout = m_laps[m_age];
    if (le) begin
      m_laps.delete(); m_bad = 0; m_age = 0;
    end else if (ce) begin
      if (all_bcd(time_in)) begin
        m_laps.push_front(time_in);
        if (m_laps.size() > DEPTH) void'(m_laps.pop_back());
        m_age = 0;
      end else m_bad = 1;
    end else if (ne && m_recall_mode && m_laps.size() > 0) begin
      m_age = (m_age + 1) % m_laps.size();
    end
    if (!m_recall_mode) begin
      m_age = 0;
      if (recall) m_recall_mode = 1;
    end else if (!recall) m_recall_mode = 0;
    p_cap = capture; p_clr = clear; p_nxt = next;
    @(posedge clk); #1;
    e_out = nout;
    check_outputs();
  endtask

  task automatic press_capture(input logic [15:0] v);
    time_in = v; capture = 1; tick(); capture = 0; tick();
  endtask
  task automatic press_next();
    next = 1; tick(); next = 0; tick();
  endtask
  task automatic press_clear();
    clear = 1; tick(); clear = 0; tick();
  endtask

  function automatic logic [15:0] rand_time();
    logic [15:0] t;
    for (int i = 0; i < 4; i++) begin
      t[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    end
    return t;
  endfunction

  initial begin
    rst_n = 0; time_in = '0; capture = 0; clear = 0; recall = 0; next = 0;
    model_reset();
    #7;
    check_outputs();
    @(negedge clk); rst_n = 1;

    // Plan 1: three laps, replay with wrap.
    press_capture(16'h0012);
    press_capture(16'h0345);
    press_capture(16'h1059);
    recall = 1; tick(); tick();
    chk("p1_count", 32'(lap_count), 32'd3);
    chk("p1_out0",  32'(lap_out), 32'h1059);
    press_next();
    chk("p1_out1",  32'(lap_out), 32'h0345);
    chk("p1_idx1",  32'(lap_idx), 32'd1);
    press_next();
    chk("p1_out2",  32'(lap_out), 32'h0012);
    press_next();
    chk("p1_wrap",  32'(lap_out), 32'h1059);
    chk("p1_idxw",  32'(lap_idx), 32'd0);

    // Plan 2: overflow past DEPTH.
    recall = 0; press_clear();
    for (int i = 1; i <= DEPTH + 2; i++) press_capture(16'(i));
    recall = 1; tick(); tick();
    chk("p2_full",   32'(full), 32'd1);
    chk("p2_newest", 32'(lap_out), 32'h0009);
    for (int i = 0; i < DEPTH - 1; i++) press_next();
    chk("p2_oldest", 32'(lap_out), 32'h0003);

    // Plan 3: rejected capture and clear.
    press_capture(16'h00A3);
    chk("p3_bad",   32'(bad_bcd), 32'd1);
    chk("p3_count", 32'(lap_count), 32'd7);
    press_clear();
    chk("p3_clr",   32'(bad_bcd), 32'd0);
    chk("p3_cnt0",  32'(lap_count), 32'd0);

    // Plan 4: simultaneous capture and clear.
    recall = 0; tick();
    press_capture(16'h0101); press_capture(16'h0202);
    capture = 1; clear = 1; time_in = 16'h0303; tick();
    capture = 0; clear = 0; tick();
    recall = 1; tick(); tick();
    chk("p4_count", 32'(lap_count), 32'd0);
    chk("p4_valid", 32'(valid), 32'd0);
    chk("p4_out",   32'(lap_out), 32'd0);

    // Plan 5: capture while replaying an older lap.
    press_capture(16'h0111); press_capture(16'h0222); press_capture(16'h0333);
    press_next(); press_next();
    chk("p5_idx2", 32'(lap_idx), 32'd2);
    time_in = 16'h0777; capture = 1; tick();
    chk("p5_idx0", 32'(lap_idx), 32'd0);
    capture = 0; tick();
    chk("p5_out",  32'(lap_out), 32'h0777);

    // Plan 6: asynchronous reset mid-replay.
    #2; rst_n = 0; #1;
    model_reset();
    check_outputs();
    @(negedge clk); rst_n = 1;
    tick();
    chk("p6_valid", 32'(valid), 32'd0);
    chk("p6_count", 32'(lap_count), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      time_in = rand_time();
      capture = ($urandom_range(0, 3) == 0);
      clear   = ($urandom_range(0, 40) == 0);
      next    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 25) == 0) recall = ~recall;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
